// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NUM_REQ requesters share one FIFO write port.
// Define FIFO_ARB_BURST_EN to let an owner keep the grant for up to BURST_LEN transfers.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [WIDTH-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                xfer_count
);

    localparam int GW = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_param
            $error("fifo_wr_arbiter: NUM_REQ or BURST_LEN out of range");
        end
    endgenerate

    logic [0:0]   r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_owner;
    logic [15:0]  r_xfer;

    logic          w_found;
    logic [GW-1:0] w_next;
    logic [GW:0]   w_idx;
    logic          w_owner_valid;
    logic          w_wr;
    logic          w_last_beat;
    logic          w_release;
    logic [WIDTH-1:0]   w_sel_data;
    logic [NUM_REQ-1:0] w_ready;

    // Search upward from the requester after the last owner, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last_owner} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (GW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_next  = w_idx[GW-1:0];
            end
        end
    end

    assign w_owner_valid = req_valid[r_grant];
    assign w_wr          = (r_state == OWN) && w_owner_valid && !fifo_full;
    assign w_release     = !w_owner_valid || (w_wr && w_last_beat);

    always_comb begin
        w_sel_data = '0;
        w_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_data = req_data[i*WIDTH +: WIDTH];
                w_ready[i] = w_wr;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    logic [3:0] r_beat;

    // Beats only advance on real transfers, so a full-FIFO stall preserves the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (r_state == OWN) begin
            if (w_release) begin
                r_beat <= '0;
            end else if (w_wr) begin
                r_beat <= r_beat + 4'd1;
            end
        end else begin
            r_beat <= '0;
        end
    end

    assign w_last_beat = (r_beat == 4'(BURST_LEN - 1));
`else
    assign w_last_beat = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_owner <= GW'(NUM_REQ - 1);
            r_xfer       <= '0;
        end else begin
            if (w_wr) begin
                r_xfer <= r_xfer + 16'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next;
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (w_release) begin
                        r_last_owner <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_wr    = w_wr;
    assign req_ready  = w_ready;
    assign fifo_data  = (r_state == OWN) ? w_sel_data : '0;
    assign grant_id   = r_grant;
    assign busy       = (r_state == OWN);
    assign xfer_count = r_xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, burst/single release, stall, mid-burst reset, counter wrap.
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .WIDTH(8),
        .NUM_REQ(4),
        .BURST_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wr(fifo_wr),
        .fifo_data(fifo_data),
        .grant_id(grant_id),
        .busy(busy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Each helper checks the cycle whose inputs were just driven, then moves to the next negedge.
    task automatic exp_idle(input string tag);
        #1;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr"}, fifo_wr, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_data"}, fifo_data, 0);
        @(negedge clk);
    endtask

    task automatic exp_write(input string tag, input int id);
        #1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_grant"}, grant_id, id);
        chk({tag, "_wr"}, fifo_wr, 1);
        chk({tag, "_data"}, fifo_data, 8'h10 + id);
        chk({tag, "_ready"}, req_ready, 1 << id);
        @(negedge clk);
    endtask

    task automatic exp_stall(input string tag, input int id);
        #1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_grant"}, grant_id, id);
        chk({tag, "_wr"}, fifo_wr, 0);
        chk({tag, "_ready"}, req_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int cyc;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        fifo_full = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_xfer", xfer_count, 0);

        // Single requester 0 with 0xA5: one idle cycle, then the write
        @(negedge clk);
        rst = 1'b0;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        exp_idle("s1_idle");
        #1;
        chk("s1_wr", fifo_wr, 1);
        chk("s1_data", fifo_data, 8'hA5);
        chk("s1_ready", req_ready, 4'b0001);
        chk("s1_grant", grant_id, 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("s1_xfer", xfer_count, 1);
        chk("s1_after_wr", fifo_wr, 0);
        @(negedge clk);
        req_data[7:0] = 8'h10;

        // All four valid: grant order 0,1,2,3,0 with an idle cycle before each grant
        do_reset();
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_idle("rr_idle");
            repeat (BL) exp_write("rr", g % 4);
        end
        req_valid = '0;
        #1;
        chk("rr_xfer", xfer_count, 5 * BL);
        @(negedge clk);

        // Requesters 1 and 2: BL writes from 1, idle cycle, BL writes from 2
        do_reset();
        req_valid = 4'b0110;
        exp_idle("bu_idle1");
        repeat (BL) exp_write("bu_r1", 1);
        exp_idle("bu_idle2");
        repeat (BL) exp_write("bu_r2", 2);
        req_valid = '0;
        exp_idle("bu_end");
        chk("bu_xfer", xfer_count, 2 * BL);

        // Full stall for 3 cycles in OWN while other requests come and go
        do_reset();
        req_valid = 4'b0001;
        exp_idle("st_idle");
`ifdef FIFO_ARB_BURST_EN
        exp_write("st_pre", 0);
        exp_write("st_pre", 0);
`endif
        fifo_full = 1'b1;
        exp_stall("st_full1", 0);
        req_valid = 4'b1111;
        exp_stall("st_full2", 0);
        req_valid = 4'b1011;
        exp_stall("st_full3", 0);
        fifo_full = 1'b0;
        req_valid = 4'b0001;
`ifdef FIFO_ARB_BURST_EN
        repeat (2) exp_write("st_post", 0);
`else
        exp_write("st_post", 0);
`endif
        req_valid = '0;
        exp_idle("st_end");
        chk("st_xfer", xfer_count, BL);

        // Reset asserted while owner 2 is mid-transfer
        do_reset();
        req_valid = 4'b0100;
        exp_idle("mr_idle");
`ifdef FIFO_ARB_BURST_EN
        exp_write("mr_b", 2);
        exp_write("mr_b", 2);
`else
        exp_write("mr_b", 2);
        exp_idle("mr_gap");
`endif
        rst = 1'b1;
        #1;
        chk("mr_wr", fifo_wr, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_data", fifo_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_xfer", xfer_count, 0);
        chk("mr_grant", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0101;
        exp_idle("mr_post_idle");
        exp_write("mr_next", 0);
        req_valid = '0;

        // 65536 transfers bring the counter back to zero
        do_reset();
        req_valid = 4'b0001;
        n = 0;
        cyc = 0;
        while (n < 65535 && cyc < 300000) begin
            #1;
            if (fifo_wr) n++;
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("wrap_ffff", xfer_count, 16'hFFFF);
        while (n < 65536 && cyc < 300000) begin
            #1;
            if (fifo_wr) n++;
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("wrap_zero", xfer_count, 16'h0000);
        chk("wrap_budget", (cyc < 300000), 1);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, equal to the shared FIFO WIDTH.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, legal 2..8: number of write requesters.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, legal 1..16: maximum beats per grant when bursting is compiled in.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i offers a word.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*WIDTH bits: slice [i*WIDTH +: WIDTH] is requester i's word.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot or zero; bit i high means requester i's word is consumed this cycle.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: full flag of the shared FIFO.
REQ-010 The block SHALL have port fifo_wr, output, 1 bit: write strobe to the shared FIFO.
REQ-011 The block SHALL have port fifo_data, output, WIDTH bits: write data to the shared FIFO.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current owner, valid when busy is high.
REQ-013 The block SHALL have port busy, output, 1 bit: high in state OWN.
REQ-014 The block SHALL have port xfer_count, output, 16 bits: total accepted words, wrapping modulo 2^16.

Function
REQ-015 The block SHALL implement a two-state FSM with states IDLE and OWN.
REQ-016 In IDLE, when any req_valid bit is high, the block SHALL register as grant_id the first valid index found searching upward from (last_owner+1) mod NUM_REQ, and SHALL enter OWN on the next edge.
REQ-017 In IDLE, req_ready and fifo_wr SHALL be 0, so arbitration latency is exactly one cycle.
REQ-018 In OWN, fifo_wr and req_ready[grant_id] SHALL equal req_valid[grant_id] AND NOT fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 fifo_data SHALL equal the req_data slice of grant_id in OWN, and all zeros in IDLE.
REQ-020 A transfer occurs on each cycle with fifo_wr high; xfer_count SHALL increment by 1 per transfer, wrapping from 0xFFFF to 0x0000.
REQ-021 In OWN, the block SHALL return to IDLE, storing last_owner = grant_id, on the edge after: (a) req_valid[grant_id] is low, or (b) the transfer completing the burst limit (REQ-027/028).
REQ-022 While fifo_full is high in OWN with the owner valid, the block SHALL hold grant and stall without counting beats.
REQ-023 A requester SHALL NOT be granted twice in a row while another requester is valid in IDLE (round-robin fairness).
REQ-024 Requests arriving or dropping while another owner is active SHALL NOT change grant_id.

Reset
REQ-025 Asserting rst SHALL immediately force: state IDLE, grant_id 0, last_owner NUM_REQ-1 (so requester 0 is searched first), beat counter 0, xfer_count 0, busy 0, fifo_wr 0, req_ready 0, fifo_data 0.
REQ-026 Reset asserted mid-burst SHALL abort the burst; no write SHALL be issued in the cycle rst is high.

Configuration
REQ-027 With macro FIFO_ARB_BURST_EN defined, an owner SHALL keep the grant for up to BURST_LEN transfers, a 4-bit beat counter tracking them, and SHALL release after the BURST_LEN-th transfer.
REQ-028 Without FIFO_ARB_BURST_EN, the block SHALL release after every single transfer, making BURST_LEN unused and no beat counter exist.

Verification
REQ-029 The bench SHALL cover this reset scenario: after rst, req_valid=4'b0001 with data 0xA5 -> IDLE for 1 cycle, then fifo_wr=1, fifo_data=0xA5, req_ready=4'b0001, and xfer_count=1.
REQ-030 The bench SHALL cover this round-robin scenario: all four valid continuously with no burst macro -> grant order 0,1,2,3,0, with one write per two cycles.
REQ-031 The bench SHALL cover this burst scenario: with FIFO_ARB_BURST_EN, BURST_LEN=4, and requesters 1 and 2 valid -> four consecutive writes from 1, one idle cycle, then four from 2.
REQ-032 The bench SHALL cover this full-stall scenario: fifo_full=1 for 3 cycles in OWN -> fifo_wr=0 and req_ready=0 for 3 cycles, grant_id unchanged, and the burst resumes with the beat count preserved.
REQ-033 The bench SHALL cover this mid-burst reset scenario: rst pulsed after 2 beats -> outputs 0 in the same cycle, xfer_count=0, and the next grant goes to requester 0.
REQ-034 The bench SHALL cover this wrap scenario: 65536 transfers -> xfer_count returns to 0x0000.
